pc_stack_counter: RTL and testbench
===================================

# pc_stack_counter

Parametrised program-counter register for the processor datapath, successor to the single-purpose R7 counter. Supports load, increment by a configurable step, signed relative branch, and a small hardware call/return stack of configurable depth. Sits in the register file as the PC slot, driven by the control FSM; Q feeds the address mux.

## Interface
- N, 16, datapath/PC width in bits
- STEP, 1, increment amount applied on Prox (unsigned, < 2^N)
- DEPTH, 4, return-stack entries (≥1)
- RESET_VAL, 0, value of Q after Clear
- Clock  input  1  rising-edge clock
- Clear  input  1  asynchronous, active-high reset
- R  input  N  load/call target
- RIn  input  1  load Q <= R
- Prox  input  1  increment Q <= Q + STEP
- BrEn  input  1  relative branch Q <= Q + Off
- Off  input  N  two's-complement branch offset
- Call  input  1  push Q + STEP, then Q <= R
- Ret  input  1  pop top of stack into Q
- Q  output  N  current PC (registered)
- Empty  output  1  stack holds 0 entries
- Full  output  1  stack holds DEPTH entries
- Err  output  1  sticky: push on full or pop on empty occurred

## Operation
- One command per edge; priority RIn > Call > Ret > BrEn > Prox; lower-priority strobes in the same cycle are ignored entirely (no stack side effects).
- No strobe asserted: Q and stack hold.
- Arithmetic modulo 2^N: Q = 2^N−1 with Prox (STEP=1) wraps to 0; Q + Off discards carry; Off sign-extended implicitly by width match.
- Stack pointer SP counts entries, width $clog2(DEPTH+1); Empty = (SP==0), Full = (SP==DEPTH), both combinational from SP.
- Call: stack[SP] <= Q + STEP (mod 2^N), SP <= SP+1, Q <= R.
- Call while Full: Q <= R still; push dropped, SP and contents unchanged, Err <= 1.
- Ret: Q <= stack[SP−1], SP <= SP−1.
- Ret while Empty: Q holds, SP stays 0, Err <= 1.
- Err is sticky; cleared only by Clear.
- Clear (any time, including mid-command): Q <= RESET_VAL, SP <= 0, Err <= 0 immediately, independent of Clock; stack contents need not be cleared (unreachable when SP=0).

## Timing
- All state updates on rising Clock; effect visible on Q/Empty/Full/Err after that edge (latency 1 cycle from strobe sampled).
- Back-to-back Call, Ret on consecutive cycles legal; Ret sees the entry pushed on the previous edge.
- Clear assertion acts asynchronously; deassertion must meet recovery time to Clock; strobes on the first edge after release are honoured.
- Reset values: Q=RESET_VAL, Empty=1, Full=0, Err=0.

## Configuration
- PC_STACK_EN defined: stack, SP, Call push, Ret pop, Full/Err logic compiled in as above.
- PC_STACK_EN undefined: no storage; Call behaves exactly as RIn (Q <= R); Ret is a no-op (Q holds); Empty tied 1, Full tied 0, Err tied 0. Port list unchanged.

## Structure
- Shared package: command-priority encoding constants (CMD_LOAD, CMD_CALL, CMD_RET, CMD_BR, CMD_INC, CMD_NONE) and default N.
- One sub-module: pc_ret_stack (DEPTH×N LIFO with push/pop/SP, Empty/Full, overflow/underflow pulses); top holds Q, priority decode, Err register. Instantiated only under PC_STACK_EN.

## Test plan
- Clear pulse mid-cycle with Q=0x0042 -> Q=0x0000, Empty=1, Err=0 before next edge; Prox ×3 -> Q=0x0003.
- Q=0xFFFF, Prox -> Q=0x0000; Q=0x0010, BrEn Off=0xFFFC -> Q=0x000C.
- Q=0x0010, Call R=0x0100 -> Q=0x0100, Empty=0; Ret -> Q=0x0011, Empty=1.
- DEPTH=4: five Calls R=0x0A,0x0B,0x0C,0x0D,0x0E from Q=0 -> Q=0x0E, Full=1, Err=1; four Rets -> Q=0x0D,0x0C,0x0B,0x01.
- Ret on Empty with Q=0x0020 -> Q=0x0020, Err=1; RIn and Call together, R=0x0300 -> Q=0x0300, SP unchanged.
- Build without PC_STACK_EN: Call R=0x0050 -> Q=0x0050; Ret -> Q holds; Empty=1, Full=0, Err=0 throughout.

Source files
------------

// File: rtl/pc_stack_counter_pkg.sv
// Shared command encoding and defaults for the program-counter slot.
// Command codes are ordered by decode priority: load, call, ret, branch, increment.
package pc_stack_counter_pkg;

    localparam int PC_N_DEFAULT = 16;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_LOAD = 3'd1;
    localparam logic [2:0] CMD_CALL = 3'd2;
    localparam logic [2:0] CMD_RET  = 3'd3;
    localparam logic [2:0] CMD_BR   = 3'd4;
    localparam logic [2:0] CMD_INC  = 3'd5;

    // Exactly one command wins per edge; lower strobes are dropped entirely.
    function automatic logic [2:0] decode_cmd(
        input logic rin,
        input logic call,
        input logic ret,
        input logic br,
        input logic inc
    );
        if (rin)       return CMD_LOAD;
        else if (call) return CMD_CALL;
        else if (ret)  return CMD_RET;
        else if (br)   return CMD_BR;
        else if (inc)  return CMD_INC;
        else           return CMD_NONE;
    endfunction

endpackage

// File: rtl/pc_stack_counter_ret_stack.sv
// DEPTH x N return-address LIFO; pointer counts entries, top read combinationally.
// Push on full / pop on empty are dropped and flagged with single-cycle pulses.
module pc_ret_stack #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] push_data,
    output logic [N-1:0] top_data,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp;
    logic [N-1:0]   mem [2**AW];
    logic           do_push;
    logic           do_pop;

    assign empty     = (sp == '0);
    assign full      = (sp == SPW'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !push && !empty;
    assign overflow  = push && full;
    assign underflow = pop && !push && empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sp <= '0;
        else if (do_push)
            sp <= sp + 1'b1;
        else if (do_pop)
            sp <= sp - 1'b1;
    end

    // Contents are left alone on reset: nothing is reachable while sp is zero.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[AW'(sp)] <= push_data;
    end

    assign top_data = mem[AW'(sp - 1'b1)];

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with load/increment/relative branch and optional call/return stack.
// Return stack is compiled in only when PC_STACK_EN is defined; otherwise Call = load, Ret = hold.
module pc_stack_counter
    import pc_stack_counter_pkg::*;
#(
    parameter int          N         = PC_N_DEFAULT,
    parameter int unsigned STEP      = 1,
    parameter int          DEPTH     = 4,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         Clock,
    input  logic         Clear,
    input  logic [N-1:0] R,
    input  logic         RIn,
    input  logic         Prox,
    input  logic         BrEn,
    input  logic [N-1:0] Off,
    input  logic         Call,
    input  logic         Ret,
    output logic [N-1:0] Q,
    output logic         Empty,
    output logic         Full,
    output logic         Err
);

    localparam logic [N-1:0] STEP_N = N'(STEP);

    logic [2:0]   cmd;
    logic [N-1:0] ret_val;
    logic [N-1:0] q_next;

    assign cmd = decode_cmd(RIn, Call, Ret, BrEn, Prox);

`ifdef PC_STACK_EN
    logic [N-1:0] stk_top;
    logic         stk_empty;
    logic         stk_over;
    logic         stk_under;

    pc_ret_stack #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (Clock),
        .rst       (Clear),
        .push      (cmd == CMD_CALL),
        .pop       (cmd == CMD_RET),
        .push_data (Q + STEP_N),
        .top_data  (stk_top),
        .empty     (stk_empty),
        .full      (Full),
        .overflow  (stk_over),
        .underflow (stk_under)
    );

    assign Empty   = stk_empty;
    assign ret_val = stk_empty ? Q : stk_top;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            Err <= 1'b0;
        else if (stk_over || stk_under)
            Err <= 1'b1;
    end
`else
    assign ret_val = Q;
    assign Empty   = 1'b1;
    assign Full    = 1'b0;
    assign Err     = 1'b0;
`endif

    always_comb begin
        q_next = Q;
        case (cmd)
            CMD_LOAD, CMD_CALL: q_next = R;
            CMD_RET:            q_next = ret_val;
            CMD_BR:             q_next = Q + Off;
            CMD_INC:            q_next = Q + STEP_N;
            default:            q_next = Q;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            Q <= RESET_VAL;
        else
            Q <= q_next;
    end

endmodule

// File: tb/tb_pc_stack_counter.sv
// Randomised and directed bench for pc_stack_counter against a queue-based PC model.
// Works for both builds; the model's call/return behaviour follows PC_STACK_EN.
module tb_pc_stack_counter;

    localparam int N     = 16;
    localparam int STEP  = 1;
    localparam int DEPTH = 4;
    localparam logic [N-1:0] RV = 16'h0000;

    logic         Clock = 1'b0;
    logic         Clear = 1'b0;
    logic [N-1:0] R = '0;
    logic         RIn = 1'b0;
    logic         Prox = 1'b0;
    logic         BrEn = 1'b0;
    logic [N-1:0] Off = '0;
    logic         Call = 1'b0;
    logic         Ret = 1'b0;
    logic [N-1:0] Q;
    logic         Empty;
    logic         Full;
    logic         Err;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: PC value, return addresses as a queue, sticky error.
    logic [N-1:0] m_q;
    logic [N-1:0] m_stk [$];
    logic         m_err;

    pc_stack_counter #(
        .N         (N),
        .STEP      (STEP),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .Clock (Clock),
        .Clear (Clear),
        .R     (R),
        .RIn   (RIn),
        .Prox  (Prox),
        .BrEn  (BrEn),
        .Off   (Off),
        .Call  (Call),
        .Ret   (Ret),
        .Q     (Q),
        .Empty (Empty),
        .Full  (Full),
        .Err   (Err)
    );

    always #5 Clock = ~Clock;

    function automatic logic [N+2:0] expect_vec();
        return {m_q, m_stk.size() == 0, m_stk.size() == DEPTH, m_err};
    endfunction

    task automatic model_reset();
        m_q = RV;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic rin, input logic call, input logic ret,
                              input logic br, input logic inc,
                              input logic [N-1:0] r, input logic [N-1:0] off);
        if (rin) begin
            m_q = r;
        end else if (call) begin
`ifdef PC_STACK_EN
            if (m_stk.size() == DEPTH) m_err = 1'b1;
            else m_stk.push_back(m_q + N'(STEP));
`endif
            m_q = r;
        end else if (ret) begin
`ifdef PC_STACK_EN
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_q = m_stk.pop_back();
`endif
        end else if (br) begin
            m_q = m_q + off;
        end else if (inc) begin
            m_q = m_q + N'(STEP);
        end
    endtask

    // Applies one cycle of strobes starting at a negedge and returns at the next negedge.
    task automatic cycle(input logic rin, input logic call, input logic ret,
                         input logic br, input logic inc,
                         input logic [N-1:0] r, input logic [N-1:0] off);
        RIn = rin; Call = call; Ret = ret; BrEn = br; Prox = inc; R = r; Off = off;
        @(posedge Clock);
        model_step(rin, call, ret, br, inc, r, off);
        #1;
        RIn = 0; Call = 0; Ret = 0; BrEn = 0; Prox = 0;
        @(negedge Clock);
    endtask

    task automatic async_clear();
        Clear = 1'b1;
        #1;
        model_reset();
        #1;
        Clear = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        logic [N+2:0] obs;
        Clear = 1'b1;
        @(negedge Clock);
        model_reset();
        obs = {Q, Empty, Full, Err};
        n_total++;
        if (obs !== expect_vec()) $display("FAIL reset_state: got %h expected %h", obs, expect_vec());
        else n_pass++;
        Clear = 1'b0;
        @(negedge Clock);
        cycle(1, 0, 0, 0, 0, 16'h0042, 0);
        n_total++;
        if (Q !== 16'h0042) $display("FAIL load_42: got %h expected 0042", Q);
        else n_pass++;
        // Pulse Clear between edges and look before the next rising edge.
        Clear = 1'b1;
        #1;
        obs = {Q, Empty, Full, Err};
        model_reset();
        n_total++;
        if (obs !== {16'h0000, 1'b1, 1'b0, 1'b0}) $display("FAIL async_clear: got %h expected %h", obs, {16'h0000, 3'b100});
        else n_pass++;
        #1;
        Clear = 1'b0;
        @(negedge Clock);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (Q !== 16'h0003) $display("FAIL prox_x3: got %h expected 0003", Q);
        else n_pass++;
    endtask

    task automatic test_arith();
        cycle(1, 0, 0, 0, 0, 16'hFFFF, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        n_total++;
        if (Q !== 16'h0000) $display("FAIL wrap_inc: got %h expected 0000", Q);
        else n_pass++;
        cycle(1, 0, 0, 0, 0, 16'h0010, 0);
        cycle(0, 0, 0, 1, 0, 0, 16'hFFFC);
        n_total++;
        if (Q !== 16'h000C) $display("FAIL branch_neg: got %h expected 000c", Q);
        else n_pass++;
        cycle(0, 0, 0, 1, 1, 0, 16'h0100);
        n_total++;
        if (Q !== 16'h010C) $display("FAIL br_over_inc: got %h expected 010c", Q);
        else n_pass++;
        cycle(0, 0, 0, 0, 0, 16'h7777, 16'h1111);
        n_total++;
        if (Q !== 16'h010C) $display("FAIL idle_hold: got %h expected 010c", Q);
        else n_pass++;
    endtask

    task automatic test_call_ret();
        logic [N+2:0] obs;
        async_clear();
        cycle(1, 0, 0, 0, 0, 16'h0010, 0);
        cycle(0, 1, 0, 0, 0, 16'h0100, 0);
        obs = {Q, Empty, Full, Err};
        n_total++;
        if (obs !== expect_vec()) $display("FAIL call: got %h expected %h", obs, expect_vec());
        else n_pass++;
        cycle(0, 0, 1, 0, 0, 0, 0);
        obs = {Q, Empty, Full, Err};
        n_total++;
        if (obs !== expect_vec()) $display("FAIL ret: got %h expected %h", obs, expect_vec());
        else n_pass++;
`ifdef PC_STACK_EN
        n_total++;
        if (Q !== 16'h0011) $display("FAIL ret_addr: got %h expected 0011", Q);
        else n_pass++;
`endif
    endtask

    task automatic test_overflow();
        logic [N+2:0] obs;
        logic [N-1:0] targets [5];
        targets = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E};
        async_clear();
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, targets[i], 0);
        obs = {Q, Empty, Full, Err};
        n_total++;
        if (obs !== expect_vec()) $display("FAIL five_calls: got %h expected %h", obs, expect_vec());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0, 0, 0, 0);
            obs = {Q, Empty, Full, Err};
            n_total++;
            if (obs !== expect_vec()) $display("FAIL ret_%0d: got %h expected %h", i, obs, expect_vec());
            else n_pass++;
        end
    endtask

    task automatic test_underflow_priority();
        logic [N+2:0] obs;
        async_clear();
        cycle(1, 0, 0, 0, 0, 16'h0020, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        obs = {Q, Empty, Full, Err};
        n_total++;
        if (obs !== expect_vec()) $display("FAIL ret_empty: got %h expected %h", obs, expect_vec());
        else n_pass++;
        cycle(1, 1, 1, 1, 1, 16'h0300, 16'h0005);
        obs = {Q, Empty, Full, Err};
        n_total++;
        if (obs !== expect_vec()) $display("FAIL rin_over_call: got %h expected %h", obs, expect_vec());
        else n_pass++;
        // Call beats Ret in the same cycle; the following Ret sees the push.
        cycle(0, 1, 1, 0, 0, 16'h0400, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        obs = {Q, Empty, Full, Err};
        n_total++;
        if (obs !== expect_vec()) $display("FAIL call_then_ret: got %h expected %h", obs, expect_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N+2:0] obs;
        int errs = 0;
        async_clear();
        for (int i = 0; i < 600; i++) begin
            if (i % 97 == 96) begin
                async_clear();
            end else begin
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 1) == 0, N'($urandom), N'($urandom));
            end
            obs = {Q, Empty, Full, Err};
            n_total++;
            if (obs !== expect_vec()) begin
                errs++;
                if (errs < 10) $display("FAIL random_%0d: got %h expected %h", i, obs, expect_vec());
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge Clock);
        test_reset();
        test_arith();
        test_call_ret();
        test_overflow();
        test_underflow_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
